// File: rtl/cdc_xfer_arbiter.sv
// cdc_xfer_arbiter: round-robin scheduler sharing one 4-phase req/ack crossing among NREQ requesters.
// Define CDC_XFER_TIMEOUT_EN to abort a handshake phase after TIMEOUT cycles without ack progress.
module cdc_xfer_arbiter #(
  parameter int NREQ    = 4,
  parameter int DWIDTH  = 32,
  parameter int SRCW    = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DWIDTH-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic                   xfer_req,
  output logic [DWIDTH-1:0]      xfer_data,
  output logic [SRCW-1:0]        xfer_src,
  input  logic                   xfer_ack_sync,
  output logic                   busy,
  output logic                   timeout_err
);
  localparam int PW = $clog2(NREQ);
  typedef enum logic [1:0] {IDLE, REQ, REL} state_t;
  state_t            state_q, state_d;
  logic              xfer_req_q, xfer_req_d;
  logic [DWIDTH-1:0] xfer_data_q, xfer_data_d;
  logic [SRCW-1:0]   xfer_src_q, xfer_src_d;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]     win, idx;
  logic [NREQ-1:0]   gnt;
  logic              any_vld, accept, to_hit;
  if (SRCW < PW || TIMEOUT < 0) begin : g_bad_cfg
    $error("cdc_xfer_arbiter: SRCW too narrow for NREQ or negative TIMEOUT");
  end
  // Descending scan so the last hit is the first set bit at or after rr_ptr.
  always_comb begin
    win = '0;
    idx = '0;
    any_vld = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = PW'((int'(rr_ptr_q) + k) % NREQ);
      if (req_valid[idx]) begin
        win = idx;
        any_vld = 1'b1;
      end
    end
  end
  assign gnt       = NREQ'(1) << win;
  assign accept    = (state_q == IDLE) && !xfer_ack_sync && any_vld;
  assign req_ready = {NREQ{accept && rst_n}} & gnt;
`ifdef CDC_XFER_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_err_q, timeout_err_d;
  assign to_hit = (TIMEOUT != 0) && (cnt_q + CW'(1) == CW'(TIMEOUT));
  // An ack arriving on the limit cycle completes the phase normally.
  always_comb begin
    cnt_d = (state_d != state_q) ? '0 : cnt_q + CW'(1);
    timeout_err_d = to_hit && ((state_q == REQ) ? !xfer_ack_sync : (state_q == REL) && xfer_ack_sync);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end
  assign timeout_err = timeout_err_q;
`else
  assign to_hit      = 1'b0;
  assign timeout_err = 1'b0;
`endif
  always_comb begin
    state_d     = state_q;
    xfer_req_d  = xfer_req_q;
    xfer_data_d = xfer_data_q;
    xfer_src_d  = xfer_src_q;
    rr_ptr_d    = rr_ptr_q;
    if (state_q == IDLE) begin
      if (accept) begin
        state_d     = REQ;
        xfer_req_d  = 1'b1;
        xfer_data_d = req_data[int'(win)*DWIDTH +: DWIDTH];
        xfer_src_d  = SRCW'(win);
        rr_ptr_d    = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
      end
    end else if (state_q == REQ) begin
      if (xfer_ack_sync || to_hit) begin
        state_d    = REL;
        xfer_req_d = 1'b0;
      end
    end else if (!xfer_ack_sync || to_hit) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      xfer_req_q  <= 1'b0;
      xfer_data_q <= '0;
      xfer_src_q  <= '0;
      rr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      xfer_req_q  <= xfer_req_d;
      xfer_data_q <= xfer_data_d;
      xfer_src_q  <= xfer_src_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end
  assign xfer_req  = xfer_req_q;
  assign xfer_data = xfer_data_q;
  assign xfer_src  = xfer_src_q;
  assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_cdc_xfer_arbiter.sv
// tb_cdc_xfer_arbiter: scoreboard bench with a far-domain ack model for cdc_xfer_arbiter.
module tb_cdc_xfer_arbiter;
  localparam int NREQ = 4, DWIDTH = 32, SRCW = 2, TIMEOUT = 8;
  logic                   clk = 1'b0;
  logic                   rst_n = 1'b1;
  logic [NREQ-1:0]        req_valid = '0;
  logic [NREQ*DWIDTH-1:0] req_data = '0;
  logic [NREQ-1:0]        req_ready;
  logic                   xfer_req, busy, timeout_err, xfer_ack_sync;
  logic [DWIDTH-1:0]      xfer_data;
  logic [SRCW-1:0]        xfer_src;
  logic                   far_en = 1'b0, far_ack = 1'b0, man_ack = 1'b0;
  typedef struct packed {logic [SRCW-1:0] src; logic [DWIDTH-1:0] data;} exp_t;
  exp_t sb[$];
  int compared = 0, mismatched = 0, model_ptr = 0;

  assign xfer_ack_sync = far_en ? far_ack : man_ack;
  always #5 clk = ~clk;

  cdc_xfer_arbiter #(.NREQ(NREQ), .DWIDTH(DWIDTH), .SRCW(SRCW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .xfer_req(xfer_req), .xfer_data(xfer_data), .xfer_src(xfer_src), .xfer_ack_sync(xfer_ack_sync),
    .busy(busy), .timeout_err(timeout_err));

  // Far domain: ack 3 cycles after req rises, release 3 cycles after req falls.
  initial begin
    int hi, lo;
    hi = 0;
    lo = 0;
    forever begin
      @(negedge clk);
      if (!far_en) begin
        far_ack = 1'b0; hi = 0; lo = 0;
      end else if (xfer_req === 1'b1 && !far_ack) begin
        hi++;
        if (hi == 3) begin far_ack = 1'b1; hi = 0; end
      end else if (xfer_req === 1'b0 && far_ack) begin
        lo++;
        if (lo == 3) begin far_ack = 1'b0; lo = 0; end
      end else begin
        hi = 0; lo = 0;
      end
    end
  end

  // Pops the expected grant on every rising xfer_req; payload must then stay put while busy.
  initial begin
    logic prev;
    logic [DWIDTH-1:0] cur;
    exp_t e;
    prev = 1'b0;
    cur = '0;
    forever begin
      @(negedge clk);
      if (xfer_req === 1'b1 && prev === 1'b0) begin
        compared++;
        if (sb.size() == 0) begin
          mismatched++;
          $display("FAIL sb_unexpected: grant src=%0d data=%h with nothing expected", xfer_src, xfer_data);
        end else begin
          e = sb.pop_front();
          cur = e.data;
          if (xfer_src !== e.src || xfer_data !== e.data) begin
            mismatched++;
            $display("FAIL sb_grant: got src=%0d data=%h, want src=%0d data=%h", xfer_src, xfer_data, e.src, e.data);
          end
        end
      end else if (busy === 1'b1 && rst_n) begin
        compared++;
        if (xfer_data !== cur) begin
          mismatched++;
          $display("FAIL sb_stable: xfer_data=%h changed while busy, want %h", xfer_data, cur);
        end
      end
      prev = xfer_req;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic step;
    @(negedge clk);
    #2;
  endtask

  task automatic wait_busy(input logic v, input int lim);
    for (int i = 0; i < lim && busy !== v; i++) step();
  endtask

  task automatic present(input logic [NREQ-1:0] mask, output int w);
    w = -1;
    for (int k = 0; k < NREQ; k++)
      if (w < 0 && mask[(model_ptr + k) % NREQ]) w = (model_ptr + k) % NREQ;
    sb.push_back('{src: SRCW'(w), data: req_data[w*DWIDTH +: DWIDTH]});
    model_ptr = (w + 1) % NREQ;
    req_valid = mask;
    #1;
  endtask

  task automatic test_reset;
    req_valid = 4'b0001;
    #3 rst_n = 1'b0;
    #1;
    compared++;
    if ({xfer_req, xfer_data, xfer_src, busy, timeout_err} !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: req=%b data=%h src=%0d busy=%b terr=%b, want all 0", xfer_req, xfer_data, xfer_src, busy, timeout_err);
    end
    compared++;
    if (req_ready !== 4'b0000) begin
      mismatched++;
      $display("FAIL reset_ready: req_ready=%b, want 0000", req_ready);
    end
    repeat (2) step();
    req_valid = '0;
    rst_n = 1'b1;
    step();
    compared++;
    if (busy !== 1'b0 || xfer_req !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_release: busy=%b xfer_req=%b, want 0 0", busy, xfer_req);
    end
  endtask

  task automatic test_fairness;
    int w;
    logic [NREQ-1:0] exp_rr;
    for (int i = 0; i < NREQ; i++) req_data[i*DWIDTH +: DWIDTH] = 32'hA5A5_0000 + i;
    far_en = 1'b1;
    for (int g = 0; g < 6; g++) begin
      wait_busy(1'b0, 60);
      present(4'b1111, w);
      exp_rr = NREQ'(1) << (g % NREQ);
      compared++;
      if (req_ready !== exp_rr) begin
        mismatched++;
        $display("FAIL fair_grant%0d: req_ready=%b, want %b", g, req_ready, exp_rr);
      end
      step();
    end
    req_valid = '0;
    wait_busy(1'b0, 60);
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("FAIL fair_drain: busy=%b, want 0", busy);
    end
  endtask

  task automatic test_single;
    int w, n;
    req_data[2*DWIDTH +: DWIDTH] = 32'hDEADBEEF;
    present(4'b0100, w);
    compared++;
    if (req_ready !== 4'b0100 || xfer_req !== 1'b0) begin
      mismatched++;
      $display("FAIL single_accept: req_ready=%b xfer_req=%b, want 0100 0", req_ready, xfer_req);
    end
    step();
    compared++;
    if (req_ready !== 4'b0000 || xfer_req !== 1'b1 || busy !== 1'b1) begin
      mismatched++;
      $display("FAIL single_req: req_ready=%b xfer_req=%b busy=%b, want 0000 1 1", req_ready, xfer_req, busy);
    end
    req_valid = '0;
    n = 0;
    while (xfer_ack_sync !== 1'b1 && n < 20) begin step(); n++; end
    compared++;
    if (xfer_ack_sync !== 1'b1 || xfer_req !== 1'b1) begin
      mismatched++;
      $display("FAIL single_ack: ack=%b xfer_req=%b, want 1 1", xfer_ack_sync, xfer_req);
    end
    step();
    compared++;
    if (xfer_req !== 1'b0 || busy !== 1'b1) begin
      mismatched++;
      $display("FAIL single_rel: xfer_req=%b busy=%b, want 0 1", xfer_req, busy);
    end
    n = 0;
    while (xfer_ack_sync !== 1'b0 && n < 20) begin step(); n++; end
    compared++;
    if (busy !== 1'b1) begin
      mismatched++;
      $display("FAIL single_rel_hold: busy=%b, want 1", busy);
    end
    step();
    compared++;
    if (busy !== 1'b0 || xfer_data !== 32'hDEADBEEF || xfer_src !== 2'd2) begin
      mismatched++;
      $display("FAIL single_done: busy=%b data=%h src=%0d, want 0 deadbeef 2", busy, xfer_data, xfer_src);
    end
  endtask

  task automatic test_stale_ack;
    int w;
    far_en = 1'b0;
    man_ack = 1'b1;
    present(4'b0001, w);
    compared++;
    if (req_ready !== 4'b0000) begin
      mismatched++;
      $display("FAIL stale_ready: req_ready=%b, want 0000", req_ready);
    end
    step();
    compared++;
    if (xfer_req !== 1'b0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL stale_hold: xfer_req=%b busy=%b, want 0 0", xfer_req, busy);
    end
    man_ack = 1'b0;
    #1;
    compared++;
    if (req_ready !== 4'b0001) begin
      mismatched++;
      $display("FAIL stale_grant: req_ready=%b, want 0001", req_ready);
    end
    step();
    compared++;
    if (xfer_req !== 1'b1) begin
      mismatched++;
      $display("FAIL stale_req: xfer_req=%b, want 1", xfer_req);
    end
    req_valid = '0;
    far_en = 1'b1;
    wait_busy(1'b0, 60);
  endtask

  task automatic test_timeout;
    int w, n;
    logic terr_seen;
    far_en = 1'b0;
    man_ack = 1'b0;
    present(4'b1000, w);
    step();
    req_valid = '0;
    n = 0;
    terr_seen = 1'b0;
`ifdef CDC_XFER_TIMEOUT_EN
    while (xfer_req === 1'b1 && n < 30) begin
      n++;
      if (timeout_err !== 1'b0) terr_seen = 1'b1;
      step();
    end
    compared++;
    if (n != 8 || terr_seen) begin
      mismatched++;
      $display("FAIL to_req_len: xfer_req high %0d cycles early_err=%b, want 8 0", n, terr_seen);
    end
    compared++;
    if (timeout_err !== 1'b1) begin
      mismatched++;
      $display("FAIL to_req_pulse: timeout_err=%b, want 1", timeout_err);
    end
    step();
    compared++;
    if (timeout_err !== 1'b0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL to_req_end: timeout_err=%b busy=%b, want 0 0", timeout_err, busy);
    end
    present(4'b0010, w);
    step();
    man_ack = 1'b1;
    step();
    compared++;
    if (xfer_req !== 1'b0 || busy !== 1'b1) begin
      mismatched++;
      $display("FAIL to_rel_enter: xfer_req=%b busy=%b, want 0 1", xfer_req, busy);
    end
    n = 0;
    while (busy === 1'b1 && n < 30) begin n++; step(); end
    compared++;
    if (n != 8 || timeout_err !== 1'b1) begin
      mismatched++;
      $display("FAIL to_rel_len: REL lasted %0d cycles terr=%b, want 8 1", n, timeout_err);
    end
    compared++;
    if (req_ready !== 4'b0000 || xfer_req !== 1'b0) begin
      mismatched++;
      $display("FAIL to_rel_stale: req_ready=%b xfer_req=%b, want 0000 0", req_ready, xfer_req);
    end
    req_valid = '0;
    man_ack = 1'b0;
    step();
    compared++;
    if (timeout_err !== 1'b0) begin
      mismatched++;
      $display("FAIL to_rel_pulse: timeout_err=%b, want 0", timeout_err);
    end
`else
    while (xfer_req === 1'b1 && n < 30) begin
      n++;
      if (timeout_err !== 1'b0) terr_seen = 1'b1;
      step();
    end
    compared++;
    if (n != 30 || terr_seen) begin
      mismatched++;
      $display("FAIL to_none: xfer_req high %0d cycles err=%b, want 30 0", n, terr_seen);
    end
    man_ack = 1'b1;
    step();
    step();
    man_ack = 1'b0;
    step();
    step();
    compared++;
    if (busy !== 1'b0 || xfer_req !== 1'b0) begin
      mismatched++;
      $display("FAIL to_none_end: busy=%b xfer_req=%b, want 0 0", busy, xfer_req);
    end
`endif
  endtask

  task automatic test_reset_mid_req;
    int w;
    far_en = 1'b0;
    man_ack = 1'b0;
    req_data[1*DWIDTH +: DWIDTH] = 32'h1234_5678;
    present(4'b0100, w);
    step();
    req_valid = 4'b1010;
    compared++;
    if (xfer_req !== 1'b1) begin
      mismatched++;
      $display("FAIL rst_mid_pre: xfer_req=%b, want 1", xfer_req);
    end
    #1 rst_n = 1'b0;
    #1;
    compared++;
    if ({xfer_req, xfer_data, xfer_src, busy} !== '0 || req_ready !== 4'b0000) begin
      mismatched++;
      $display("FAIL rst_mid_drop: req=%b data=%h src=%0d busy=%b ready=%b, want all 0", xfer_req, xfer_data, xfer_src, busy, req_ready);
    end
    model_ptr = 0;
    step();
    rst_n = 1'b1;
    present(4'b1010, w);
    compared++;
    if (req_ready !== 4'b0010) begin
      mismatched++;
      $display("FAIL rst_mid_first: req_ready=%b, want 0010", req_ready);
    end
    step();
    compared++;
    if (xfer_req !== 1'b1 || xfer_src !== 2'd1) begin
      mismatched++;
      $display("FAIL rst_mid_grant: xfer_req=%b src=%0d, want 1 1", xfer_req, xfer_src);
    end
    req_valid = '0;
    far_en = 1'b1;
    wait_busy(1'b0, 60);
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("FAIL rst_mid_drain: busy=%b, want 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_single();
    test_stale_ack();
    test_timeout();
    test_reset_mid_req();
    step();
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL sb_leftover: %0d expected grants never seen, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
